seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 44 ++++
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu_mul.sv | 47 ++++
 rtl/seq_alu.sv | 139 +++++++++++++
 tb/tb_seq_alu.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and flag bit positions.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ASR = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10,
    OP_CMP = 4'd11,
    OP_MUL = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } st_e;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_C   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_ERR = 4;

  function automatic logic [4:0] pack_flags(input logic err, input logic v, input logic c,
                                            input logic n, input logic z);
    logic [4:0] f;
    f           = '0;
    f[FLAG_ERR] = err;
    f[FLAG_V]   = v;
    f[FLAG_C]   = c;
    f[FLAG_N]   = n;
    f[FLAG_Z]   = z;
    return f;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operation/result bus of the sequential ALU.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds valid and its payload stable until that edge.
interface seq_alu_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Unsigned shift-add multiplier: WIDTH iterations, one per clock after i_start.
// o_done flags the final iteration; o_product is the value that iteration produces.
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign o_product  = w_acc_next;
  assign o_done     = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= i_a;
      r_acc   <= {{WIDTH{1'b0}}, i_b};
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops plus an iterative multiply, one registered result slot.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_alu_if.slave    bus,
  output st_e         o_dbg_state
);
  st_e              r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_flags;

  op_e                w_op;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [4:0]         w_mul_flags;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_zn;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic             w_zn_diff;
  logic [4:0]       w_alu_flags;

  assign w_op       = op_e'(bus.op);
  assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (w_op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  assign w_mul_flags = pack_flags(1'b0, |w_product[2*WIDTH-1:WIDTH], |w_product[2*WIDTH-1:WIDTH],
                                  w_product[WIDTH-1], ~|w_product[WIDTH-1:0]);

  // Borrow of A-B is the top bit of the zero-extended difference.
  assign w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff    = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
  assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_err     = 1'b0;
    w_zn_diff = 1'b0;
    case (w_op)
      OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH];  w_v = w_add_ovf; end
      OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; w_v = w_sub_ovf; end
      OP_AND: w_res = bus.a & bus.b;
      OP_OR:  w_res = bus.a | bus.b;
      OP_XOR: w_res = bus.a ^ bus.b;
      OP_NOT: w_res = ~bus.a;
      OP_SHL: begin w_res = {bus.a[WIDTH-2:0], 1'b0};            w_c = bus.a[WIDTH-1]; end
      OP_SHR: begin w_res = {1'b0, bus.a[WIDTH-1:1]};            w_c = bus.a[0]; end
      OP_ASR: begin w_res = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};  w_c = bus.a[0]; end
      OP_ROL: begin w_res = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};  w_c = bus.a[WIDTH-1]; end
      OP_ROR: begin w_res = {bus.a[0], bus.a[WIDTH-1:1]};        w_c = bus.a[0]; end
      OP_CMP: begin
        w_res     = bus.a;
        w_c       = w_diff[WIDTH];
        w_v       = w_sub_ovf;
        w_zn_diff = 1'b1;
      end
      OP_MUL: begin end
      default: w_err = 1'b1;
    endcase
  end

  assign w_zn        = w_zn_diff ? w_diff[WIDTH-1:0] : w_res;
  assign w_alu_flags = pack_flags(w_err, w_v, w_c, w_zn[WIDTH-1], ~|w_zn);

  // An accept in DONE retires the held result and loads the next op at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state     <= ST_MUL;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_res;
              r_flags     <= w_alu_flags;
            end
          end else if ((r_state == ST_DONE) && bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_product[WIDTH-1:0];
            r_flags     <= w_mul_flags;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): directed corner cases, then randomized ops against a reference model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W     = 8;
  localparam int BOUND = 60;
  typedef logic [W+4:0] obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus();
  st_e  dbg_state;
  logic rdy_rand    = 1'b0;
  logic rdy_force   = 1'b1;
  logic rdy_rnd_bit = 1'b1;

  assign bus.out_ready = rdy_rand ? rdy_rnd_bit : rdy_force;

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ERR,V,C,N,Z,result} from plain integer arithmetic.
  function automatic obs_t ref_alu(input logic [3:0] op, input logic [W-1:0] a_in,
                                   input logic [W-1:0] b_in);
    longint unsigned a, b, m, r, zn, p;
    longint sa, sb, s, smax, smin;
    logic c, v, e;
    a    = 64'(a_in);
    b    = 64'(b_in);
    m    = (64'd1 << W) - 64'd1;
    smax = (64'sd1 <<< (W - 1)) - 64'sd1;
    smin = -smax - 64'sd1;
    sa   = a_in[W-1] ? longint'(a) - longint'(m) - 64'sd1 : longint'(a);
    sb   = b_in[W-1] ? longint'(b) - longint'(m) - 64'sd1 : longint'(b);
    c = 1'b0; v = 1'b0; e = 1'b0; r = 0; zn = 0; p = 0; s = 0;
    case (op)
      4'd0:  begin r = a + b; c = (r > m); r = r & m; s = sa + sb; v = (s > smax) || (s < smin); end
      4'd1:  begin r = (a - b) & m; c = (a < b); s = sa - sb; v = (s > smax) || (s < smin); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (~a) & m;
      4'd6:  begin r = (a << 1) & m; c = ((a >> (W - 1)) != 0); end
      4'd7:  begin r = a >> 1; c = ((a & 1) != 0); end
      4'd8:  begin r = (a >> 1) | (a & (64'd1 << (W - 1))); c = ((a & 1) != 0); end
      4'd9:  begin r = ((a << 1) | (a >> (W - 1))) & m; c = ((a >> (W - 1)) != 0); end
      4'd10: begin r = (a >> 1) | ((a & 1) << (W - 1)); c = ((a & 1) != 0); end
      4'd11: begin zn = (a - b) & m; r = a; c = (a < b); s = sa - sb; v = (s > smax) || (s < smin); end
      4'd12: begin p = a * b; r = p & m; c = ((p >> W) != 0); v = c; end
      default: e = 1'b1;
    endcase
    if (op != 4'd11) zn = r;
    return {e, v, c, zn[W-1], (zn == 0), r[W-1:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    rdy_rnd_bit <= ($urandom_range(0, 3) != 0);
  end

  // Scoreboard: queue the model's answer at each accept, compare at each retire.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_spurious", 64'(bus.out_valid), 64'(0));
        else check("sb_result", 64'({bus.flags, bus.result}), 64'(exp_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_alu(bus.op, bus.a, bus.b));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int waited);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    waited       = 0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
  endtask

  task automatic wait_out(output int cyc, output int viol);
    cyc  = 0;
    viol = 0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) break;
      if (bus.in_ready) viol++;
    end
    if (!bus.out_valid) check("out_timeout", 64'(bus.out_valid), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, w1, w2, lat, viol, ov;
    logic [W-1:0] ra, rb;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.op       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_flags", 64'(bus.flags), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    sync();
    issue(4'd0, 8'h7F, 8'h01, w0);
    wait_out(lat, viol);
    check("add_latency", 64'(lat), 64'(1));
    check("add_ovf", 64'({bus.flags, bus.result}), 64'({5'b01010, 8'h80}));

    sync();
    issue(4'd1, 8'h00, 8'h01, w0);
    wait_out(lat, viol);
    check("sub_borrow", 64'({bus.flags, bus.result}), 64'({5'b00110, 8'hFF}));

    sync();
    issue(4'd11, 8'h05, 8'h05, w0);
    wait_out(lat, viol);
    check("cmp_equal", 64'({bus.flags, bus.result}), 64'({5'b00001, 8'h05}));

    sync();
    issue(4'd12, 8'h10, 8'h10, w0);
    wait_out(lat, viol);
    check("mul_latency", 64'(lat), 64'(W + 1));
    check("mul_in_ready_low", 64'(viol), 64'(0));
    check("mul_overflow", 64'({bus.flags, bus.result}), 64'({5'b01101, 8'h00}));

    sync();
    issue(4'd0, 8'h33, 8'h44, w0);
    issue(4'd4, 8'hA5, 8'h0F, w1);
    issue(4'd10, 8'h01, 8'h00, w2);
    check("b2b_no_stall", 64'(w1 + w2), 64'(0));
    @(negedge clk);
    check("ror_wrap", 64'({bus.flags, bus.result}), 64'({5'b00110, 8'h80}));

    sync();
    rdy_force = 1'b0;
    issue(4'd14, W'($urandom), W'($urandom), w0);
    wait_out(lat, viol);
    check("rsv_latency", 64'(lat), 64'(1));
    bus.in_valid = 1'b1;
    bus.op       = 4'd0;
    bus.a        = 8'h01;
    bus.b        = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_value", 64'({bus.flags, bus.result}), 64'({5'b10001, 8'h00}));
      check("hold_in_ready", 64'(bus.in_ready), 64'(0));
      check("hold_valid", 64'(bus.out_valid), 64'(1));
    end
    sync();
    bus.in_valid = 1'b0;
    rdy_force    = 1'b1;

    sync();
    issue(4'd12, W'($urandom), W'($urandom), w0);
    ov = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ov += int'(bus.out_valid);
    end
    sync();
    rst = 1'b1;
    @(negedge clk);
    ov += int'(bus.out_valid);
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    for (int k = 0; k < 12; k++) begin
      ov += int'(bus.out_valid);
      @(negedge clk);
    end
    check("abort_no_out", 64'(ov), 64'(0));
    sync();
    ra = W'($urandom);
    rb = W'($urandom);
    issue(4'd0, ra, rb, w0);
    wait_out(lat, viol);
    check("post_rst_add", 64'({bus.flags, bus.result}), 64'(ref_alu(4'd0, ra, rb)));

    sync();
    rdy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) sync();
      issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), w0);
    end
    rdy_rand = 1'b0;
    for (int k = 0; k < BOUND && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
